// File: rtl/wave_sequencer.sv
// Purpose : phase-accumulator sequencer driving an 8-bit waveform function block; samples go to the DAC stage.
// Latency : one sample tick (DIV clocks) from index presentation to sample_data/sample_valid.
// Backpr. : a tick that finds an unconsumed sample parks in STALL (acc/counter frozen) until sample_ready.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   enable             run request; sampled only at period wrap once running
//   step               phase increment per sample tick
//   f_req, f_load      waveform request and its load strobe
//   value_in           function-block result for (f_out, index_out)
//   f_out, index_out   waveform select and phase index to the function block
//   sample_data/valid  captured sample, valid/ready handshake with sample_ready
//   busy               high whenever the sequencer is not IDLE
//   sync_pulse         one-clock marker after each wrapping tick (only with WAVE_SEQ_SYNC_EN)
//
// Optional feature macro: WAVE_SEQ_SYNC_EN adds the sync_pulse output.
module wave_sequencer #(
  parameter int ACC_W = 16,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [ACC_W-1:0] step,
  input  logic [1:0]       f_req,
  input  logic             f_load,
  input  logic [7:0]       value_in,
  output logic [1:0]       f_out,
  output logic [7:0]       index_out,
  output logic [7:0]       sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             busy
`ifdef WAVE_SEQ_SYNC_EN
  ,
  output logic             sync_pulse
`endif
);

  localparam int              CNT_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t           state_q,  state_nxt;
  logic [ACC_W-1:0] acc_q,    acc_nxt;
  logic [CNT_W-1:0] cnt_q,    cnt_nxt;
  logic [1:0]       f_q,      f_nxt;
  logic [1:0]       fpend_q,  fpend_nxt;
  logic             pend_q,   pend_nxt;
  logic [7:0]       data_q,   data_nxt;
  logic             vld_q,    vld_nxt;
  logic             sync_q,   sync_nxt;

  logic [ACC_W:0]   sum;
  logic             wrap;
  logic             tick;
  logic             stall_now;
  logic             fire;
  logic             stop;

  // Carry out of the phase add marks the end of a waveform period.
  assign sum  = {1'b0, acc_q} + {1'b0, step};
  assign wrap = sum[ACC_W];

  assign tick      = (state_q == S_RUN) && (cnt_q == CNT_LAST);
  assign stall_now = tick && vld_q && !sample_ready;
  // fire = a tick that actually captures: a normal tick, or the deferred one leaving STALL.
  assign fire      = (tick && !stall_now) || ((state_q == S_STALL) && sample_ready);
  // A zero step never wraps, so a stop request is honoured on the very next tick instead.
  assign stop      = fire && !enable && (wrap || (step == '0));

  always_comb begin
    state_nxt = state_q;
    acc_nxt   = acc_q;
    cnt_nxt   = cnt_q;
    f_nxt     = f_q;
    fpend_nxt = fpend_q;
    pend_nxt  = pend_q;
    data_nxt  = data_q;
    vld_nxt   = vld_q;
    sync_nxt  = 1'b0;

    if (vld_q && sample_ready) begin
      vld_nxt = 1'b0;
    end

    if (f_load) begin
      if (state_q == S_IDLE) begin
        f_nxt = f_req;
      end else begin
        fpend_nxt = f_req;
        pend_nxt  = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        acc_nxt = '0;
        cnt_nxt = '0;
        if (enable) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (stall_now) begin
          state_nxt = S_STALL;     // counter stays at its last value
        end else if (!tick) begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_STALL: begin
        // everything frozen until the deferred tick below
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (fire) begin
      // value_in reflects the pre-update index, so the sample lags the index by one tick.
      data_nxt  = value_in;
      vld_nxt   = 1'b1;
      acc_nxt   = sum[ACC_W-1:0];
      cnt_nxt   = '0;
      state_nxt = S_RUN;
      sync_nxt  = wrap;
      if (wrap) begin
        // A strobe landing on the wrap tick itself takes effect immediately.
        if (f_load) begin
          f_nxt    = f_req;
          pend_nxt = 1'b0;
        end else if (pend_q) begin
          f_nxt    = fpend_q;
          pend_nxt = 1'b0;
        end
      end
      if (stop) begin
        state_nxt = S_IDLE;
        acc_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      f_q     <= 2'b00;
      fpend_q <= 2'b00;
      pend_q  <= 1'b0;
      data_q  <= 8'h00;
      vld_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      acc_q   <= acc_nxt;
      cnt_q   <= cnt_nxt;
      f_q     <= f_nxt;
      fpend_q <= fpend_nxt;
      pend_q  <= pend_nxt;
      data_q  <= data_nxt;
      vld_q   <= vld_nxt;
      sync_q  <= sync_nxt;
    end
  end

  assign f_out        = f_q;
  assign index_out    = acc_q[ACC_W-1 -: 8];
  assign sample_data  = data_q;
  assign sample_valid = vld_q;
  assign busy         = (state_q != S_IDLE);

`ifdef WAVE_SEQ_SYNC_EN
  assign sync_pulse = sync_q;
`else
  // Without the trigger output the marker register has no load; tie it into nothing observable.
  logic unused_sync;
  assign unused_sync = sync_q;
`endif

endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
Phase-accumulator controller for the 8-bit waveform function block (f select, 8-bit index in, 8-bit value out). It generates the index sequence at a programmable frequency and selects the waveform. Waveform changes are applied only at period boundaries. Each function-block output is captured as a sample and handed to the DAC stage over a valid/ready handshake.

Parameters:
ACC_W, 16, phase accumulator width (>= 8); index is the top 8 bits
DIV, 4, clocks per sample tick (>= 2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request
step  in  ACC_W  phase increment per sample tick (frequency tuning word)
f_req  in  2  requested waveform code (01 saw, 10 triangle, other = zero)
f_load  in  1  one-cycle strobe, latches f_req
value_in  in  8  value returned by the function block for (f_out, index_out)
f_out  out  2  waveform select to the function block
index_out  out  8  acc[ACC_W-1:ACC_W-8] to the function block
sample_data  out  8  captured sample
sample_valid  out  1  sample_data valid
sample_ready  in  1  downstream accepts sample
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0) applies immediately:
  - state=IDLE, acc=0, tick counter=0, f_out=00, f_pending=0, pend_flag=0
  - sample_data=0, sample_valid=0, busy=0
- States: IDLE, RUN, STALL.
- IDLE:
  - acc held at 0; counter held at 0.
  - f_load copies f_req straight to f_out.
  - enable=1 moves to RUN on the next edge.
- Tick: in RUN, the counter counts 0..DIV-1; tick is asserted when counter==DIV-1, and the counter then returns to 0.
- RUN, on a tick:
  - sample_data <= value_in, i.e. the value for the pre-update index (combinational path through the function block; one tick of latency).
  - sample_valid <= 1.
  - acc <= (acc + step) mod 2^ACC_W. wrap = carry out of that add.
- Handshake:
  - sample_valid clears on an edge where sample_valid & sample_ready and no new tick occurs.
  - Tick with sample_valid=1 and sample_ready=1: the old sample is consumed, the new one is loaded, and valid stays 1.
  - Tick with sample_valid=1 and sample_ready=0: go to STALL. Do not capture, do not advance acc; counter holds at DIV-1.
- STALL:
  - acc and counter are frozen; enable and wrap handling are deferred.
  - The first cycle with sample_ready=1 performs the deferred tick: capture, advance acc, counter=0, return to RUN. valid stays 1.
  - No sample is ever dropped or duplicated.
- Waveform change:
  - f_load outside IDLE latches f_req into f_pending and sets pend_flag; a later f_load overwrites it.
  - On a tick with wrap and pend_flag=1: f_out <= f_pending, pend_flag <= 0.
  - f_load coinciding with a wrap tick applies the new f_req directly at that wrap.
- Stop:
  - enable=0 in RUN finishes the current period. On a wrap tick with enable=0: state=IDLE, acc=0. That tick's sample is still captured.
  - Edge case: step==0 with enable=0 goes to IDLE on the next tick, since wrap can never occur.
- enable toggling within a period has no effect; only its value at a wrap tick matters.
- sample_valid may still be pending on entry to IDLE; it completes normally under the same clearing rule.
- busy reflects the registered state (0 only in IDLE).

Optional Feature:
WAVE_SEQ_SYNC_EN
- Defined: adds output port sync_pulse (1 bit, reset 0). It is high for exactly one clock, in the cycle after a tick that produced wrap (including the deferred tick of STALL), for scope/trigger use.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- ACC_W=16, DIV=4, step=16'h0100, f_load f_req=01 in IDLE, enable=1, sample_ready=1 -> sample_valid high 1 cycle every 4 clocks; sample_data 0,1,2,...,255,0; index wraps every 256 ticks; busy=1.
- In the above run, f_load f_req=10 when index=100 -> f_out stays 01 through index 255, becomes 10 at the tick where index goes 255->0; samples then follow the triangle (0,2,4,...).
- Hold sample_ready=0 for 12 clocks with valid pending -> STALL entered at the next tick; index_out and sample_data are frozen. On ready=1: one capture, index+1, counter=0; the sample sequence has no gaps or repeats.
- Drop enable when index=200 -> ticks continue to index 255; at the wrap state=IDLE, index_out=0, busy=0. Sample 255 is delivered before ready clears valid.
- step=16'h0000, enable=1 then 0 -> index constant. IDLE is reached on the next tick after enable=0.
- rst_n pulsed low mid-RUN between clock edges -> all outputs 0 immediately, with no clk edge required. With WAVE_SEQ_SYNC_EN: sync_pulse=1 one cycle after each 255->0 tick, 0 after reset.
